// File: rtl/csk_div_pkg.sv
// Shared constants, FSM state type and the ripple-block helper for the
// carry-skip restoring divider.
package csk_div_pkg;

   localparam int WIDTH = 16;
   localparam int CNT_W = 4;
   localparam int BLOCK = 4;
   localparam int SUB_W = WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // One BLOCK-bit ripple-carry adder slice; returns {carry_out, sum}.
   function automatic logic [BLOCK:0] ripple_blk(input logic [BLOCK-1:0] a,
                                                 input logic [BLOCK-1:0] b,
                                                 input logic             cin);
      logic             c;
      logic [BLOCK-1:0] s;
      c = cin;
      s = '0;
      for (int j = 0; j < BLOCK; j++) begin
         s[j] = a[j] ^ b[j] ^ c;
         c    = (a[j] & b[j]) | ((a[j] ^ b[j]) & c);
      end
      return {c, s};
   endfunction

endpackage

// File: rtl/csk_sub_17bit.sv
// 17-bit carry-skip subtractor: diff = a - b as a + ~b + 1.
// cout = 1 means no borrow (a >= b).
module csk_sub_17bit
   import csk_div_pkg::*;
(
   input  logic [SUB_W-1:0] a,
   input  logic [SUB_W-1:0] b,
   output logic [SUB_W-1:0] diff,
   output logic             cout
);

   localparam int NBLK = WIDTH / BLOCK;

   logic [SUB_W-1:0] bn;
   logic [SUB_W-1:0] prop;
   logic [BLOCK:0]   blk;
   logic             carry;

   assign bn   = ~b;
   assign prop = a ^ bn;

   // When every bit of a block propagates, the block's carry-in skips
   // straight to the next block instead of rippling through it.
   always_comb begin
      carry = 1'b1;
      diff  = '0;
      blk   = '0;
      for (int k = 0; k < NBLK; k++) begin
         blk = ripple_blk(a[k*BLOCK +: BLOCK], bn[k*BLOCK +: BLOCK], carry);
         diff[k*BLOCK +: BLOCK] = blk[BLOCK-1:0];
         carry = (&prop[k*BLOCK +: BLOCK]) ? carry : blk[BLOCK];
      end
      diff[WIDTH] = prop[WIDTH] ^ carry;
      cout        = prop[WIDTH] ? carry : (a[WIDTH] & bn[WIDTH]);
   end

endmodule

// File: rtl/csk_divider_16bit.sv
// Sequential 16-bit unsigned restoring divider, one quotient bit per clock,
// using the carry-skip subtractor for the trial subtraction.
module csk_divider_16bit
   import csk_div_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   // Handshake: a request is accepted on a rising edge where start=1 and
   // ready=1 (IDLE or DONE); start is ignored while busy. done pulses for
   // one cycle when results are written; results hold until the next one.

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;

   logic [WIDTH:0]   t;
   logic [WIDTH:0]   s;
   logic             no_borrow;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;
   logic             unused_s_msb;

   // The partial remainder stays below the divisor, so its top bit is always
   // zero between iterations and only 16 bits are stored.
   assign t = {r, q[WIDTH-1]};

   csk_sub_17bit u_sub (
      .a    (t),
      .b    ({1'b0, d}),
      .diff (s),
      .cout (no_borrow)
   );

   assign r_next       = no_borrow ? s[WIDTH-1:0] : t[WIDTH-1:0];
   assign q_next       = {q[WIDTH-2:0], no_borrow};
   assign unused_s_msb = s[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         ready       <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (divisor == '0) begin
                     state       <= DONE;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     busy        <= 1'b0;
                     ready       <= 1'b1;
                  end else begin
                     state       <= RUN;
                     d           <= divisor;
                     r           <= '0;
                     q           <= dividend;
                     cnt         <= CNT_W'(WIDTH - 1);
                     div_by_zero <= 1'b0;
                     busy        <= 1'b1;
                     ready       <= 1'b0;
                  end
               end else if (state == DONE) begin
                  state <= IDLE;
               end
            end
            RUN: begin
               r   <= r_next;
               q   <= q_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state     <= DONE;
                  quotient  <= q_next;
                  remainder <= r_next;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  ready     <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csk_divider_16bit.sv
// Self-checking bench for csk_divider_16bit: directed cases with literal
// results, reset/back-to-back/ignored-start scenarios and a random sweep.
module tb_csk_divider_16bit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;

   // Expected completions: {div_by_zero, quotient, remainder}.
   logic [32:0] exp_q[$];
   logic [32:0] mon_e;
   logic [15:0] hold_q;
   logic [15:0] hold_r;
   logic        hold_dbz;

   csk_divider_16bit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b);
      if (b == 16'd0) return {1'b1, 16'hFFFF, a};
      return {1'b0, 16'(a / b), 16'(a % b)};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("ready_is_not_busy", 32'(ready), 32'(!busy));
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("quotient", 32'(quotient), 32'(mon_e[31:16]));
               check("remainder", 32'(remainder), 32'(mon_e[15:0]));
               check("div_by_zero", 32'(div_by_zero), 32'(mon_e[32]));
               hold_q   = mon_e[31:16];
               hold_r   = mon_e[15:0];
               hold_dbz = mon_e[32];
            end
         end else begin
            check("hold_quotient", 32'(quotient), 32'(hold_q));
            check("hold_remainder", 32'(remainder), 32'(hold_r));
            check("hold_div_by_zero", 32'(div_by_zero), 32'(hold_dbz));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      exp_q.delete();
      hold_q   = '0;
      hold_r   = '0;
      hold_dbz = 1'b0;
      #1;
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("ready_before_start", 32'(ready), 32'd1);
   endtask

   // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [32:0] e);
      wait_ready();
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (b != 16'd0) hold_dbz = 1'b0;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
   endtask

   // Counts edges from acceptance to done and busy samples in between;
   // optionally pokes start with other operands while the divide runs.
   task automatic wait_done(input int exp_lat, input bit poke);
      int lat  = 0;
      int bcnt = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && lat < 40) begin
         if (poke && lat == 3) begin
            start    = 1'b1;
            dividend = 16'd9999;
            divisor  = 16'd3;
         end
         if (poke && lat == 5) start = 1'b0;
         @(posedge clk);
         #1;
         lat++;
         if (busy === 1'b1) bcnt++;
      end
      start = 1'b0;
      check("done_latency", 32'(lat), 32'(exp_lat));
      check("busy_cycles", 32'(bcnt), 32'(exp_lat));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] a;
      logic [15:0] b;
      int          sel;
      int          dn;

      rst_n    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      hold_q   = '0;
      hold_r   = '0;
      hold_dbz = 1'b0;
      #2;
      do_reset();
      @(posedge clk);
      #1;

      // Directed cases with hand-computed results.
      start_op(16'd100, 16'd7, {1'b0, 16'd14, 16'd2});
      wait_done(16, 1'b0);
      start_op(16'hFFFF, 16'd1, {1'b0, 16'hFFFF, 16'd0});
      wait_done(16, 1'b0);
      start_op(16'h8000, 16'h8001, {1'b0, 16'd0, 16'h8000});
      wait_done(16, 1'b0);
      start_op(16'd3, 16'd10, {1'b0, 16'd0, 16'd3});
      wait_done(16, 1'b0);
      start_op(16'd5, 16'd0, {1'b1, 16'hFFFF, 16'd5});
      wait_done(0, 1'b0);
      check("dbz_output", 32'(div_by_zero), 32'd1);

      // Start during RUN must be ignored.
      repeat (2) @(posedge clk);
      #1;
      start_op(16'd100, 16'd7, {1'b0, 16'd14, 16'd2});
      wait_done(16, 1'b1);

      // Back-to-back: request issued in the done cycle.
      check("in_done_cycle", 32'(done), 32'd1);
      start_op(16'd1000, 16'd33, {1'b0, 16'd30, 16'd10});
      wait_done(16, 1'b0);

      // Reset in the middle of an operation.
      @(posedge clk);
      #1;
      start_op(16'd100, 16'd7, {1'b0, 16'd14, 16'd2});
      repeat (8) @(posedge clk);
      #1;
      do_reset();
      dn = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) dn++;
      end
      check("no_done_after_reset", 32'(dn), 32'd0);
      start_op(16'd100, 16'd7, {1'b0, 16'd14, 16'd2});
      wait_done(16, 1'b0);

      // Random sweep against the arithmetic reference model.
      for (int i = 0; i < 2000; i++) begin
         a   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         sel = $urandom_range(0, 15);
         if (sel == 0)      b = 16'd0;
         else if (sel <= 4) b = 16'($urandom_range(1, 15));
         else if (sel == 5) b = a;
         else if (sel == 6) b = 16'hFFFF;
         else               b = 16'($urandom);
         start_op(a, b, model(a, b));
         wait_done((b == 16'd0) ? 0 : 16, 1'b0);
         if (b != 16'd0) begin
            check("div_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check("rem_below_divisor", 32'(remainder < b), 32'd1);
         end
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end

      repeat (4) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
